// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter with prioritised next-PC selection and a direct-mapped BTB
// Next-PC priority: reset > redirect > stall > BTB prediction > pc+4.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse misalign.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   stall                        hold pc (hazard unit)
//   redirect_valid/target        execute-stage redirect
//   btb_wr_en/pc/target/taken    BTB install (taken=1) or tag-matched invalidate (taken=0)
//   pc, pc_valid                 registered fetch address and its qualifier
//   pred_taken                   combinational BTB hit on the current pc
//   misalign                     one-cycle misaligned-redirect flag (0 unless the macro is defined)
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h01000000,
  parameter int              BTB_DEPTH    = 8,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h01000100
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            btb_wr_en,
  input  logic [XLEN-1:0] btb_wr_pc,
  input  logic [XLEN-1:0] btb_wr_target,
  input  logic            btb_wr_taken,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic            misalign
);
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW  = XLEN - IDX - 2;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_btb_valid  [BTB_DEPTH];
  logic [TW-1:0]   r_btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0] r_btb_target [BTB_DEPTH];
  logic [IDX-1:0]  w_rd_idx, w_wr_idx;
  logic [TW-1:0]   w_wr_tag;
  logic            w_hit;
  logic [XLEN-1:0] w_redir_pc, w_next;
  logic            w_unused;
  assign w_rd_idx = r_pc[IDX+1:2];
  assign w_wr_idx = btb_wr_pc[IDX+1:2];
  assign w_wr_tag = btb_wr_pc[XLEN-1:IDX+2];
  assign w_hit    = r_pc_valid & r_btb_valid[w_rd_idx] & (r_btb_tag[w_rd_idx] == r_pc[XLEN-1:IDX+2]);
`ifdef MISALIGN_TRAP_EN
  logic w_mis;
  logic r_misalign;
  assign w_mis      = |redirect_target[1:0];
  assign w_redir_pc = w_mis ? TRAP_VECTOR : {redirect_target[XLEN-1:2], 2'b00};
  assign misalign   = r_misalign;
  assign w_unused   = &{1'b0, btb_wr_pc[1:0]};
  always_ff @(posedge clock)
    r_misalign <= reset ? 1'b0 : redirect_valid & w_mis;
`else
  assign w_redir_pc = {redirect_target[XLEN-1:2], 2'b00};
  assign misalign   = 1'b0;
  assign w_unused   = &{1'b0, btb_wr_pc[1:0], redirect_target[1:0], TRAP_VECTOR};
`endif
  // The pc holds through the post-reset cycle unless a redirect arrives.
  assign w_next = redirect_valid            ? w_redir_pc :
                  (!r_pc_valid || stall)    ? r_pc :
                  w_hit                     ? r_btb_target[w_rd_idx] :
                                              r_pc + XLEN'(4);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      for (int i = 0; i < BTB_DEPTH; i++) r_btb_valid[i] <= 1'b0;
    end else begin
      r_pc       <= w_next;
      r_pc_valid <= 1'b1;
      if (btb_wr_en) begin
        if (btb_wr_taken) begin
          r_btb_valid[w_wr_idx]  <= 1'b1;
          r_btb_tag[w_wr_idx]    <= w_wr_tag;
          r_btb_target[w_wr_idx] <= btb_wr_target;
        end else if (r_btb_tag[w_wr_idx] == w_wr_tag) begin
          r_btb_valid[w_wr_idx]  <= 1'b0;
        end
      end
    end
  end
  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign pred_taken = w_hit;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit with directed vectors
module tb_pc_fetch_unit;
  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid, btb_wr_en, btb_wr_taken;
  logic [31:0] redirect_target, btb_wr_pc, btb_wr_target;
  logic [31:0] pc;
  logic        pc_valid, pred_taken, misalign;
  typedef struct packed {
    int          cyc;
    logic [31:0] pc;
    logic        v;
    logic        pt;
    logic        mis;
  } exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .btb_wr_taken(btb_wr_taken),
    .pc(pc), .pc_valid(pc_valid), .pred_taken(pred_taken), .misalign(misalign)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // Monitor: compares every expectation queued for the cycle that just ended.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (pc !== e.pc || pc_valid !== e.v || pred_taken !== e.pt || misalign !== e.mis) begin
          errors++;
          $display("FAIL %s: got pc=%h v=%b pt=%b mis=%b, want pc=%h v=%b pt=%b mis=%b",
                   n, pc, pc_valid, pred_taken, misalign, e.pc, e.v, e.pt, e.mis);
        end
      end
    end
  end
  // Queue the state expected right after the next rising edge, then advance to the next negedge.
  task automatic tick(input string n, input logic [31:0] epc, input logic ev, input logic ept,
                      input logic emis = 1'b0);
    exp_q.push_back('{cyc: cyc + 1, pc: epc, v: ev, pt: ept, mis: emis});
    name_q.push_back(n);
    @(negedge clock);
  endtask
  task automatic redir(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
  endtask
  task automatic btbw(input logic [31:0] wpc, input logic [31:0] wt, input logic tk);
    btb_wr_en     = 1'b1;
    btb_wr_pc     = wpc;
    btb_wr_target = wt;
    btb_wr_taken  = tk;
  endtask
  task automatic idle;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    btb_wr_en      = 1'b0;
  endtask
  initial begin
    reset = 1'b1; idle(); redirect_target = '0; btb_wr_pc = '0; btb_wr_target = '0; btb_wr_taken = 1'b0;
    tick("reset0", 32'h01000000, 0, 0);
    tick("reset1", 32'h01000000, 0, 0);
    reset = 1'b0;
    tick("first_valid", 32'h01000000, 1, 0);
    tick("seq_04", 32'h01000004, 1, 0);
    tick("seq_08", 32'h01000008, 1, 0);
    tick("seq_0c", 32'h0100000C, 1, 0);
    tick("seq_10", 32'h01000010, 1, 0);
    stall = 1'b1;
    tick("stall1", 32'h01000010, 1, 0);
    btbw(32'h01000020, 32'h01000080, 1);
    tick("stall2_btb_install", 32'h01000010, 1, 0);
    btb_wr_en = 1'b0;
    tick("stall3", 32'h01000010, 1, 0);
    redir(32'h01000400);
    tick("redirect_beats_stall", 32'h01000400, 1, 0);
    idle();
    tick("after_redirect", 32'h01000404, 1, 0);
    redir(32'h01000018);
    tick("redir_18", 32'h01000018, 1, 0);
    idle();
    tick("seq_1c", 32'h0100001C, 1, 0);
    tick("btb_hit_20", 32'h01000020, 1, 1);
    tick("btb_target_80", 32'h01000080, 1, 0);
    redir(32'h01000020);
    tick("redir_20_hit", 32'h01000020, 1, 1);
    idle(); stall = 1'b1;
    tick("stall_on_hit", 32'h01000020, 1, 1);
    stall = 1'b0;
    tick("pred_after_stall", 32'h01000080, 1, 0);
    redir(32'h01000040);
    tick("alias_40", 32'h01000040, 1, 0);
    idle();
    tick("alias_seq_44", 32'h01000044, 1, 0);
    redir(32'h01000020); btbw(32'h01000040, 32'h0, 0);
    tick("inval_wrong_tag", 32'h01000020, 1, 1);
    idle(); btbw(32'h01000020, 32'h0, 0);
    tick("inval_old_lookup", 32'h01000080, 1, 0);
    idle(); redir(32'h01000020);
    tick("inval_done", 32'h01000020, 1, 0);
    idle();
    tick("inval_seq_24", 32'h01000024, 1, 0);
    redir(32'hFFFFFFFC);
    tick("redir_top", 32'hFFFFFFFC, 1, 0);
    idle();
    tick("wrap_zero", 32'h00000000, 1, 0);
    redir(32'h01000006);
`ifdef MISALIGN_TRAP_EN
    tick("misalign_trap", 32'h01000100, 1, 0, 1);
`else
    tick("misalign_forced", 32'h01000004, 1, 0, 0);
`endif
    redir(32'h01000200);
    tick("aligned_redir", 32'h01000200, 1, 0, 0);
    idle();
    tick("seq_204", 32'h01000204, 1, 0, 0);
    reset = 1'b1; btbw(32'h01000020, 32'h01000080, 1);
    tick("reset_with_write", 32'h01000000, 0, 0);
    reset = 1'b0; idle(); redir(32'h01000020);
    tick("redir_in_invalid_cycle", 32'h01000020, 1, 0);
    idle();
    tick("post_reset_seq", 32'h01000024, 1, 0);
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
